// File: rtl/axis_frame_gen_pkg.sv
// Shared types and LFSR constants for the AXI-Stream frame generator.
// The LFSR items are only used when AXIS_FRAME_GEN_LFSR_EN is defined.
package axis_frame_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam int unsigned       LFSR_W    = 32;
    localparam logic [LFSR_W-1:0] LFSR_POLY = 32'h8020_0003;

    // Right-shifting Galois form: the bit shifted out selects the tap mask.
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_POLY : '0);
    endfunction

endpackage

// File: rtl/axis_lfsr.sv
// 32-bit Galois LFSR with synchronous seed load and step enable.
// A zero seed would lock the register up, so it is replaced by 1.
module axis_lfsr
    import axis_frame_gen_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_load,
    input  logic [LFSR_W-1:0] i_seed,
    input  logic              i_step,
    output logic [LFSR_W-1:0] o_state
);

    logic [LFSR_W-1:0] state_d, state_q;

    always_comb begin
        state_d = state_q;
        if (i_load) begin
            state_d = (i_seed == '0) ? LFSR_W'(1) : i_seed;
        end else if (i_step) begin
            state_d = lfsr_step(state_q);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_q <= LFSR_W'(1);
        end else begin
            state_q <= state_d;
        end
    end

    assign o_state = state_q;

endmodule

// File: rtl/axis_frame_gen.sv
// AXI-Stream frame transmitter: cnt frames of len beats with a gap between frames.
// Define AXIS_FRAME_GEN_LFSR_EN to take the payload from a 32-bit LFSR instead of a counter.
module axis_frame_gen
    import axis_frame_gen_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned LEN_W      = 16,
    parameter int unsigned GAP_W      = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  i_start,
    input  logic [LEN_W-1:0]      i_frame_len,
    input  logic [LEN_W-1:0]      i_frame_cnt,
    input  logic [GAP_W-1:0]      i_gap,
    input  logic [DATA_WIDTH-1:0] i_seed,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tuser,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready
);

    state_e                state_d, state_q;
    logic [LEN_W-1:0]      len_m1_d, len_m1_q, cnt_m1_d, cnt_m1_q;
    logic [LEN_W-1:0]      beat_d, beat_q, frame_d, frame_q;
    logic [GAP_W-1:0]      gap_d, gap_q, gap_cnt_d, gap_cnt_q;
    logic [DATA_WIDTH-1:0] tdata_d, tdata_q;
    logic                  tvalid_d, tvalid_q, tuser_d, tuser_q, tlast_d, tlast_q;
    logic                  busy_d, busy_q, done_d, done_q;
    logic                  start_ok, hs;
    logic [DATA_WIDTH-1:0] first_data, next_data;

    // DONE is already not busy, so a new run may start in the o_done cycle.
    assign start_ok = i_start && (i_frame_len != '0) && (i_frame_cnt != '0)
                      && ((state_q == IDLE) || (state_q == DONE));
    assign hs       = tvalid_q && m_axis_tready;

`ifdef AXIS_FRAME_GEN_LFSR_EN
    logic [LFSR_W-1:0] lfsr_seed, lfsr_state, lfsr_nxt;

    assign lfsr_seed = LFSR_W'(i_seed);

    axis_lfsr u_lfsr (
        .i_clk   (i_clk),
        .i_rstn  (i_rstn),
        .i_load  (start_ok),
        .i_seed  (lfsr_seed),
        .i_step  (hs),
        .o_state (lfsr_state)
    );

    // tdata mirrors the low LFSR bits, so the value after a step is the next payload.
    assign lfsr_nxt   = lfsr_step(lfsr_state);
    assign first_data = (lfsr_seed == '0) ? DATA_WIDTH'(1) : i_seed;
    assign next_data  = lfsr_nxt[DATA_WIDTH-1:0];
`else
    assign first_data = i_seed;
    assign next_data  = tdata_q + DATA_WIDTH'(1);
`endif

    always_comb begin
        state_d   = state_q;
        len_m1_d  = len_m1_q;
        cnt_m1_d  = cnt_m1_q;
        gap_d     = gap_q;
        beat_d    = beat_q;
        frame_d   = frame_q;
        gap_cnt_d = gap_cnt_q;
        tdata_d   = tdata_q;
        tvalid_d  = tvalid_q;
        tuser_d   = tuser_q;
        tlast_d   = tlast_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start_ok) begin
                    state_d  = SEND;
                    len_m1_d = i_frame_len - LEN_W'(1);
                    cnt_m1_d = i_frame_cnt - LEN_W'(1);
                    gap_d    = i_gap;
                    beat_d   = '0;
                    frame_d  = '0;
                    tdata_d  = first_data;
                    tvalid_d = 1'b1;
                    tuser_d  = 1'b1;
                    tlast_d  = (i_frame_len == LEN_W'(1));
                    busy_d   = 1'b1;
                end
            end
            SEND: begin
                if (hs) begin
                    tdata_d = next_data;
                    if (beat_q == len_m1_q) begin
                        beat_d  = '0;
                        tuser_d = 1'b0;
                        tlast_d = 1'b0;
                        if (frame_q == cnt_m1_q) begin
                            state_d  = DONE;
                            tvalid_d = 1'b0;
                            busy_d   = 1'b0;
                            done_d   = 1'b1;
                        end else begin
                            frame_d = frame_q + LEN_W'(1);
                            if (gap_q == '0) begin
                                tuser_d = 1'b1;
                                tlast_d = (len_m1_q == '0);
                            end else begin
                                state_d   = GAP;
                                gap_cnt_d = GAP_W'(1);
                                tvalid_d  = 1'b0;
                            end
                        end
                    end else begin
                        beat_d  = beat_q + LEN_W'(1);
                        tuser_d = 1'b0;
                        tlast_d = ((beat_q + LEN_W'(1)) == len_m1_q);
                    end
                end
            end
            GAP: begin
                if (gap_cnt_q == gap_q) begin
                    state_d  = SEND;
                    tvalid_d = 1'b1;
                    tuser_d  = 1'b1;
                    tlast_d  = (len_m1_q == '0);
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_q   <= IDLE;
            beat_q    <= '0;
            frame_q   <= '0;
            gap_cnt_q <= '0;
            tdata_q   <= '0;
            tvalid_q  <= 1'b0;
            tuser_q   <= 1'b0;
            tlast_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            frame_q   <= frame_d;
            gap_cnt_q <= gap_cnt_d;
            tdata_q   <= tdata_d;
            tvalid_q  <= tvalid_d;
            tuser_q   <= tuser_d;
            tlast_q   <= tlast_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Run parameters are only meaningful once a start is accepted.
    always_ff @(posedge i_clk) begin
        len_m1_q <= len_m1_d;
        cnt_m1_q <= cnt_m1_d;
        gap_q    <= gap_d;
    end

    assign o_busy        = busy_q;
    assign o_done        = done_q;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tuser  = tuser_q;
    assign m_axis_tlast  = tlast_q;
    assign m_axis_tvalid = tvalid_q;

endmodule

// File: tb/tb_axis_frame_gen.sv
// Scoreboard bench for axis_frame_gen: a reference model queues expected beats,
// a monitor pops and checks them on every handshake.
`timescale 1ns/1ps
module tb_axis_frame_gen;

    localparam int DW = 8;
    localparam int LW = 16;
    localparam int GW = 8;

    logic          i_clk = 1'b0;
    logic          i_rstn = 1'b0;
    logic          i_start = 1'b0;
    logic [LW-1:0] i_frame_len = '0;
    logic [LW-1:0] i_frame_cnt = '0;
    logic [GW-1:0] i_gap = '0;
    logic [DW-1:0] i_seed = '0;
    logic          o_busy, o_done;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tuser, m_axis_tlast, m_axis_tvalid;
    logic          m_axis_tready = 1'b0;

    axis_frame_gen #(.DATA_WIDTH(DW), .LEN_W(LW), .GAP_W(GW)) dut (
        .i_clk         (i_clk),
        .i_rstn        (i_rstn),
        .i_start       (i_start),
        .i_frame_len   (i_frame_len),
        .i_frame_cnt   (i_frame_cnt),
        .i_gap         (i_gap),
        .i_seed        (i_seed),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          user;
        logic          last;
        logic          fin;
        logic [GW-1:0] gap_after;
    } beat_t;

    beat_t exp_q[$];
    int    n_checks = 0;
    int    n_pass   = 0;
    int    hs_count = 0;
    int    rdy_mode = 0;
    int    pat_idx  = 0;
    int    pat_a[7] = '{1, 0, 0, 1, 0, 1, 1};

    task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, req, $time);
    endtask

    function automatic logic [31:0] lfsr_adv(input logic [31:0] s);
        logic [31:0] r;
        r = s >> 1;
        if (s[0]) r = r ^ 32'h8020_0003;
        return r;
    endfunction

    // Reference model: the full list of beats a run must produce.
    task automatic push_run(input int len, input int cnt, input int gap, input logic [DW-1:0] seed);
        logic [31:0] s;
        logic [DW-1:0] d;
        beat_t e;
        s = 32'(seed);
        if (s == 0) s = 1;
        d = seed;
        for (int f = 0; f < cnt; f++) begin
            for (int b = 0; b < len; b++) begin
`ifdef AXIS_FRAME_GEN_LFSR_EN
                e.data = s[DW-1:0];
                s = lfsr_adv(s);
`else
                e.data = d;
                d = d + 1'b1;
`endif
                e.user      = (b == 0);
                e.last      = (b == len - 1);
                e.fin       = (b == len - 1) && (f == cnt - 1);
                e.gap_after = GW'(gap);
                exp_q.push_back(e);
            end
        end
    endtask

    // tready driver: 0 = always ready, 1 = fixed stall pattern, other = random.
    initial forever begin
        @(posedge i_clk);
        #2;
        case (rdy_mode)
            0:       m_axis_tready = 1'b1;
            1:       begin m_axis_tready = pat_a[pat_idx % 7][0]; pat_idx++; end
            default: m_axis_tready = ($urandom_range(0, 9) < 7);
        endcase
    end

    // Monitor
    logic          prev_stall = 1'b0;
    logic [DW+1:0] prev_beat  = '0;
    bit            gap_pending = 0, done_pending = 0;
    int            idle_run = 0, exp_gap = 0;

    initial forever begin
        beat_t e;
        @(negedge i_clk);
        if (!i_rstn) begin
            prev_stall = 1'b0; gap_pending = 0; done_pending = 0; idle_run = 0;
        end else begin
            if (done_pending) begin
                check(o_done && !m_axis_tvalid && !o_busy, "done_pulse",
                      {o_done, m_axis_tvalid, o_busy}, 3'b100);
                done_pending = 0;
            end else begin
                check(!o_done, "no_spurious_done", o_done, 0);
            end
            if (prev_stall) begin
                check(m_axis_tvalid && ({m_axis_tdata, m_axis_tuser, m_axis_tlast} == prev_beat),
                      "hold_under_stall", {m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast},
                      {1'b1, prev_beat});
            end
            if (gap_pending) begin
                if (!m_axis_tvalid) idle_run++;
                else begin
                    check(idle_run == exp_gap, "gap_cycles", idle_run, exp_gap);
                    gap_pending = 0;
                end
            end
            if (m_axis_tvalid && m_axis_tready) begin
                hs_count++;
                if (exp_q.size() == 0) begin
                    check(0, "unexpected_beat", m_axis_tdata, 0);
                end else begin
                    e = exp_q.pop_front();
                    check({m_axis_tdata, m_axis_tuser, m_axis_tlast} == {e.data, e.user, e.last},
                          "beat", {m_axis_tdata, m_axis_tuser, m_axis_tlast}, {e.data, e.user, e.last});
                    if (e.fin) done_pending = 1;
                    else if (e.last) begin gap_pending = 1; idle_run = 0; exp_gap = int'(e.gap_after); end
                end
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_beat  = {m_axis_tdata, m_axis_tuser, m_axis_tlast};
        end
    end

    task automatic check_outputs_zero(input string name);
        check({m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast, o_busy, o_done} == '0, name,
              {m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast, o_busy, o_done}, 0);
    endtask

    task automatic start_run(input int len, input int cnt, input int gap, input logic [DW-1:0] seed,
                             input int mode, input bit accept);
        logic [DW-1:0] first;
        @(posedge i_clk); #1;
        i_frame_len = LW'(len); i_frame_cnt = LW'(cnt); i_gap = GW'(gap); i_seed = seed;
        i_start = 1'b1;
        if (accept) push_run(len, cnt, gap, seed);
        first = accept ? exp_q[0].data : '0;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        rdy_mode = mode;
        pat_idx = 0;
        i_frame_len = LW'($urandom); i_frame_cnt = LW'($urandom);
        i_gap = GW'($urandom); i_seed = DW'($urandom);
        if (accept)
            check(m_axis_tvalid && m_axis_tuser && o_busy && (m_axis_tdata == first), "first_beat",
                  {m_axis_tvalid, m_axis_tuser, o_busy, m_axis_tdata}, {3'b111, first});
    endtask

    task automatic wait_done(input int budget);
        bit seen;
        seen = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge i_clk); #1;
            if (o_done) begin seen = 1; break; end
        end
        check(seen, "done_seen", seen, 1);
        check(exp_q.size() == 0, "queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        bit reached;
        repeat (3) @(posedge i_clk);
        #1;
        check_outputs_zero("reset_state");
        i_rstn = 1'b1;

        // Basic frame, then the same run under backpressure
        start_run(4, 1, 0, 8'h10, 0, 1);
        wait_done(100);
        start_run(4, 1, 0, 8'h10, 1, 1);
        wait_done(100);

        // Gap and payload wrap; back-to-back single-beat frames
        start_run(3, 2, 2, 8'hFE, 0, 1);
        wait_done(100);
        start_run(1, 3, 0, 8'hA0, 0, 1);
        wait_done(100);

        // Rejected requests: zero length, zero count
        start_run(0, 3, 1, 8'h33, 0, 0);
        for (int i = 0; i < 6; i++) begin
            @(negedge i_clk);
            check(!o_busy && !m_axis_tvalid, "reject_len0", {o_busy, m_axis_tvalid}, 0);
        end
        start_run(2, 0, 1, 8'h33, 0, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge i_clk);
            check(!o_busy && !m_axis_tvalid, "reject_cnt0", {o_busy, m_axis_tvalid}, 0);
        end

        // Start pulsed in the middle of a run must be ignored
        start_run(4, 2, 1, 8'h20, 1, 1);
        repeat (3) @(posedge i_clk);
        #1;
        i_frame_len = 2; i_frame_cnt = 1; i_seed = 8'h55; i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        wait_done(200);
        repeat (3) @(negedge i_clk);
        check(!o_busy && !m_axis_tvalid, "idle_after_ignored_start", {o_busy, m_axis_tvalid}, 0);

        // Reset after 2 of 4 beats
        for (int k = 0; k < 2; k++) begin
            logic [DW-1:0] sd;
            sd = (k == 0) ? 8'h10 : 8'h00;
            base = hs_count;
            start_run(4, 1, 0, sd, 0, 1);
            reached = 0;
            for (int i = 0; i < 50; i++) begin
                @(negedge i_clk); #1;
                if (hs_count >= base + 2) begin reached = 1; break; end
            end
            check(reached, "two_beats_before_reset", hs_count - base, 2);
            @(posedge i_clk); #1;
            i_rstn = 1'b0;
            @(posedge i_clk); #1;
            check_outputs_zero("reset_mid_frame");
            exp_q.delete();
            i_rstn = 1'b1;
            repeat (3) @(negedge i_clk);
            check(!o_done && !m_axis_tvalid, "no_done_after_abort", {o_done, m_axis_tvalid}, 0);
            start_run(4, 1, 0, sd, 0, 1);
            wait_done(100);
        end

        // Randomized runs
        for (int r = 0; r < 8; r++) begin
            start_run($urandom_range(1, 6), $urandom_range(1, 3), $urandom_range(0, 3),
                      DW'($urandom), (r % 3 == 0) ? 1 : 2, 1);
            wait_done(500);
        end

        repeat (2) @(posedge i_clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
